// File: rtl/score_pkg.sv
// Shared types and helpers for the multi-channel reaction scorer.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DONE      = 2'd3
  } round_state_t;

  localparam logic [1:0] STREAK_MAX = 2'd3;

  // Accumulator width used by sat_add; score widths up to ACC_W are supported.
  localparam int ACC_W = 32;

  // Adds a and b and clamps the result to the largest value representable in w bits.
  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input int unsigned      w
  );
    logic [ACC_W:0] sum;
    logic [ACC_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((ACC_W+1)'(1) << w) - (ACC_W+1)'(1);
    return (sum > lim) ? lim[ACC_W-1:0] : sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/score_channel.sv
// One scoring channel: round FSM, reaction ramp, saturating score and hit streak.
// Define SCORE_COMBO_BONUS_EN to multiply the award by (1 + streak).
module score_channel
  import score_pkg::*;
#(
  parameter int PW   = 8,
  parameter int SW   = 11,
  parameter int PEAK = 4
) (
  input  logic          counter10h,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [PW-1:0] pattern,
  input  logic [PW-1:0] user_input,
  output logic [SW-1:0] score,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic [1:0]    streak
);

  localparam int RW = $clog2(PEAK + 1);
  localparam logic [RW-1:0] RAMP_PEAK = RW'(PEAK);
  localparam logic [RW-1:0] RAMP_ONE  = RW'(1);

  round_state_t  state_reg, state_next;
  logic [RW-1:0] ramp_reg, ramp_next;
  logic [PW-1:0] cur_pattern_reg, cur_pattern_next;
  logic [SW-1:0] score_reg, score_next;
  logic [1:0]    streak_reg, streak_next;
  logic          hit_reg, hit_next;
  logic          miss_reg, miss_next;

  logic          round_open;
  logic          pattern_change;
  logic          hit_ev;
  logic          expire_ev;
  logic          miss_ev;
  logic [SW-1:0] award;
  logic [SW-1:0] score_sum;

  assign round_open     = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);
  assign pattern_change = (pattern != cur_pattern_reg);
  // A pattern change masks any match arriving on the same edge.
  assign hit_ev         = !pattern_change && round_open && (user_input == cur_pattern_reg);
  assign expire_ev      = !pattern_change && !hit_ev && (state_reg == RAMP_DOWN) && (ramp_reg == '0);
  assign miss_ev        = (pattern_change && round_open) || expire_ev;

`ifdef SCORE_COMBO_BONUS_EN
  assign award = SW'(ramp_reg) * (SW'(streak_reg) + SW'(1));
`else
  assign award = SW'(ramp_reg);
`endif

  assign score_sum = SW'(sat_add(ACC_W'(score_reg), ACC_W'(award), SW));

  always_ff @(posedge counter10h or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ramp_reg        <= '0;
      cur_pattern_reg <= '0;
      score_reg       <= '0;
      streak_reg      <= '0;
      hit_reg         <= 1'b0;
      miss_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ramp_reg        <= ramp_next;
      cur_pattern_reg <= cur_pattern_next;
      score_reg       <= score_next;
      streak_reg      <= streak_next;
      hit_reg         <= hit_next;
      miss_reg        <= miss_next;
    end
  end

  // Round progression is independent of clear.
  always_comb begin
    state_next       = state_reg;
    ramp_next        = ramp_reg;
    cur_pattern_next = cur_pattern_reg;
    if (pattern_change) begin
      cur_pattern_next = pattern;
      ramp_next        = '0;
      state_next       = (pattern != '0) ? RAMP_UP : IDLE;
    end else if (hit_ev) begin
      state_next = DONE;
      ramp_next  = '0;
    end else begin
      case (state_reg)
        RAMP_UP: begin
          if (ramp_reg == RAMP_PEAK) begin
            state_next = RAMP_DOWN;
            ramp_next  = RAMP_PEAK - RAMP_ONE;
          end else begin
            ramp_next = ramp_reg + RAMP_ONE;
          end
        end
        RAMP_DOWN: begin
          if (ramp_reg == '0) begin
            state_next = DONE;
          end else begin
            ramp_next = ramp_reg - RAMP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    score_next  = score_reg;
    streak_next = streak_reg;
    hit_next    = hit_ev;
    miss_next   = miss_ev;
    if (hit_ev) begin
      score_next  = score_sum;
      streak_next = (streak_reg == STREAK_MAX) ? STREAK_MAX : streak_reg + 2'd1;
    end else if (miss_ev) begin
      streak_next = '0;
    end
    if (clear) begin
      score_next  = '0;
      streak_next = '0;
      hit_next    = 1'b0;
      miss_next   = 1'b0;
    end
  end

  assign score      = score_reg;
  assign streak     = streak_reg;
  assign hit_pulse  = hit_reg;
  assign miss_pulse = miss_reg;

endmodule

// File: rtl/score_calculator_mc.sv
// Multi-channel reaction scorer: CH independent score_channel instances on packed buses.
// Define SCORE_COMBO_BONUS_EN to enable the streak-multiplied award in every channel.
module score_calculator_mc
  import score_pkg::*;
#(
  parameter int CH   = 2,
  parameter int PW   = 8,
  parameter int SW   = 11,
  parameter int PEAK = 4
) (
  input  logic             counter10h,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CH*PW-1:0] pattern,
  input  logic [CH*PW-1:0] user_input,
  output logic [CH*SW-1:0] score_out,
  output logic [CH-1:0]    hit_pulse,
  output logic [CH-1:0]    miss_pulse,
  output logic [CH*2-1:0]  streak_out
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    score_channel #(
      .PW   (PW),
      .SW   (SW),
      .PEAK (PEAK)
    ) u_channel (
      .counter10h (counter10h),
      .rst_n      (rst_n),
      .clear      (clear),
      .pattern    (pattern[gi*PW +: PW]),
      .user_input (user_input[gi*PW +: PW]),
      .score      (score_out[gi*SW +: SW]),
      .hit_pulse  (hit_pulse[gi]),
      .miss_pulse (miss_pulse[gi]),
      .streak     (streak_out[gi*2 +: 2])
    );
  end

endmodule

// File: tb/tb_score_calculator_mc.sv
// Directed table-driven bench for score_calculator_mc, with a second 4-bit-score instance for saturation.
module tb_score_calculator_mc;

  localparam int CH   = 2;
  localparam int PW   = 8;
  localparam int SW   = 11;
  localparam int SWS  = 4;
  localparam int PEAK = 4;

  logic              counter10h = 1'b0;
  logic              rst_n      = 1'b0;
  logic              clear      = 1'b0;
  logic [CH*PW-1:0]  pattern    = '0;
  logic [CH*PW-1:0]  user_input = '0;
  logic [CH*SW-1:0]  score_out;
  logic [CH-1:0]     hit_pulse;
  logic [CH-1:0]     miss_pulse;
  logic [CH*2-1:0]   streak_out;
  logic [CH*SWS-1:0] score_sat;
  logic [CH-1:0]     hit_sat;
  logic [CH-1:0]     miss_sat;
  logic [CH*2-1:0]   streak_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int p0, u0, p1, u1, clr;
    int sc0, sc0c, h0, m0, k0;
    int sc1, h1, m1, k1;
  } vec_t;

  vec_t tbl[$];

  always #5 counter10h = ~counter10h;

  score_calculator_mc #(.CH(CH), .PW(PW), .SW(SW), .PEAK(PEAK)) dut (
    .counter10h (counter10h),
    .rst_n      (rst_n),
    .clear      (clear),
    .pattern    (pattern),
    .user_input (user_input),
    .score_out  (score_out),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .streak_out (streak_out)
  );

  score_calculator_mc #(.CH(CH), .PW(PW), .SW(SWS), .PEAK(PEAK)) dut_sat (
    .counter10h (counter10h),
    .rst_n      (rst_n),
    .clear      (clear),
    .pattern    (pattern),
    .user_input (user_input),
    .score_out  (score_sat),
    .hit_pulse  (hit_sat),
    .miss_pulse (miss_sat),
    .streak_out (streak_sat)
  );

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int sc0, input int h0, input int m0, input int k0,
                           input int sc1, input int h1, input int m1, input int k1);
    chk({tag, ".c0.score"},  int'(score_out[SW-1:0]),   sc0);
    chk({tag, ".c0.hit"},    int'(hit_pulse[0]),        h0);
    chk({tag, ".c0.miss"},   int'(miss_pulse[0]),       m0);
    chk({tag, ".c0.streak"}, int'(streak_out[1:0]),     k0);
    chk({tag, ".c1.score"},  int'(score_out[2*SW-1:SW]), sc1);
    chk({tag, ".c1.hit"},    int'(hit_pulse[1]),        h1);
    chk({tag, ".c1.miss"},   int'(miss_pulse[1]),       m1);
    chk({tag, ".c1.streak"}, int'(streak_out[3:2]),     k1);
    chk({tag, ".c0.sat"},    int'(score_sat[SWS-1:0]),  sat15(sc0));
    chk({tag, ".c1.sat"},    int'(score_sat[2*SWS-1:SWS]), sat15(sc1));
  endtask

  task automatic add(input int n, input int p0, input int u0, input int p1, input int u1, input int clr,
                     input int sc0, input int sc0c, input int h0, input int m0, input int k0,
                     input int sc1, input int h1, input int m1, input int k1);
    vec_t v;
    v.n = n; v.p0 = p0; v.u0 = u0; v.p1 = p1; v.u1 = u1; v.clr = clr;
    v.sc0 = sc0; v.sc0c = sc0c; v.h0 = h0; v.m0 = m0; v.k0 = k0;
    v.sc1 = sc1; v.h1 = h1; v.m1 = m1; v.k1 = k1;
    tbl.push_back(v);
  endtask

  task automatic drive(input int p0, input int u0, input int p1, input int u1, input int clr);
    pattern    = {8'(p1), 8'(p0)};
    user_input = {8'(u1), 8'(u0)};
    clear      = clr[0];
  endtask

  initial begin
    int exp0;
    // n, p0, u0, p1, u1, clr | sc0, sc0(combo), hit0, miss0, streak0 | sc1, hit1, miss1, streak1
    add(1, 'h5A, 'h00, 'h77, 'h00, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0); // load both rounds
    add(3, 'h5A, 'h00, 'h77, 'h00, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0); // ramp 1..3
    add(1, 'h5A, 'h5A, 'h77, 'h00, 0,   3,  3, 1, 0, 1,   0, 0, 0, 0); // hit at ramp 3
    add(1, 'h5A, 'h5A, 'h77, 'h77, 0,   3,  3, 0, 0, 1,   4, 1, 0, 1); // held match; ch1 hit at peak
    add(3, 'h5A, 'h5A, 'h77, 'h77, 0,   3,  3, 0, 0, 1,   4, 0, 0, 1); // held matches never re-award
    add(1, 'h3C, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 1,   4, 0, 0, 1); // load from DONE: no miss
    add(8, 'h3C, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 1,   4, 0, 0, 1); // ramp 1,2,3,4,3,2,1,0
    add(1, 'h3C, 'h00, 'h77, 'h77, 0,   3,  3, 0, 1, 0,   4, 0, 0, 1); // expiry miss
    add(1, 'h3C, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 0,   4, 0, 0, 1);
    add(1, 'h11, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 0,   4, 0, 0, 1);
    add(5, 'h11, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 0,   4, 0, 0, 1); // into RAMP_DOWN
    add(1, 'h22, 'h11, 'h77, 'h77, 0,   3,  3, 0, 1, 0,   4, 0, 0, 1); // abandon beats match
    add(1, 'h22, 'h00, 'h77, 'h77, 0,   3,  3, 0, 0, 0,   4, 0, 0, 1);
    add(1, 'h22, 'h22, 'h77, 'h77, 0,   4,  4, 1, 0, 1,   4, 0, 0, 1); // ramp restarted: award 1
    add(1, 'h33, 'h00, 'h77, 'h77, 0,   4,  4, 0, 0, 1,   4, 0, 0, 1);
    add(4, 'h33, 'h00, 'h77, 'h77, 0,   4,  4, 0, 0, 1,   4, 0, 0, 1);
    add(1, 'h33, 'h33, 'h77, 'h77, 0,   8, 12, 1, 0, 2,   4, 0, 0, 1); // award 4 (combo 8)
    add(1, 'h44, 'h00, 'h77, 'h77, 0,   8, 12, 0, 0, 2,   4, 0, 0, 1);
    add(3, 'h44, 'h00, 'h77, 'h77, 0,   8, 12, 0, 0, 2,   4, 0, 0, 1);
    add(1, 'h44, 'h44, 'h77, 'h77, 0,  11, 21, 1, 0, 3,   4, 0, 0, 1); // award 3 (combo 9)
    add(1, 'h55, 'h00, 'h77, 'h77, 0,  11, 21, 0, 0, 3,   4, 0, 0, 1);
    add(2, 'h55, 'h00, 'h77, 'h77, 0,  11, 21, 0, 0, 3,   4, 0, 0, 1);
    add(1, 'h55, 'h55, 'h77, 'h77, 0,  13, 29, 1, 0, 3,   4, 0, 0, 1); // award 2 (combo 8), streak stays 3
    add(1, 'h66, 'h00, 'h77, 'h77, 0,  13, 29, 0, 0, 3,   4, 0, 0, 1);
    add(7, 'h66, 'h00, 'h77, 'h77, 0,  13, 29, 0, 0, 3,   4, 0, 0, 1);
    add(1, 'h66, 'h66, 'h77, 'h77, 0,  14, 33, 1, 0, 3,   4, 0, 0, 1); // hit on the way down, ramp 1
    add(1, 'h12, 'h00, 'h77, 'h77, 0,  14, 33, 0, 0, 3,   4, 0, 0, 1);
    add(3, 'h12, 'h00, 'h77, 'h77, 0,  14, 33, 0, 0, 3,   4, 0, 0, 1);
    add(1, 'h12, 'h12, 'h77, 'h77, 0,  17, 45, 1, 0, 3,   4, 0, 0, 1); // 4-bit copy: 14+3 -> 15
    add(1, 'h12, 'h12, 'h77, 'h77, 1,   0,  0, 0, 0, 0,   0, 0, 0, 0); // clear
    add(1, 'h12, 'h12, 'h77, 'h77, 0,   0,  0, 0, 0, 0,   0, 0, 0, 0);

    // Reset state, sampled while reset is held.
    repeat (2) @(negedge counter10h);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
`ifdef SCORE_COMBO_BONUS_EN
      exp0 = tbl[i].sc0c;
`else
      exp0 = tbl[i].sc0;
`endif
      $display("row %0d: n=%0d p0=%02h u0=%02h p1=%02h u1=%02h clr=%0d exp_sc0=%0d exp_sc1=%0d",
               i, tbl[i].n, tbl[i].p0, tbl[i].u0, tbl[i].p1, tbl[i].u1, tbl[i].clr, exp0, tbl[i].sc1);
      for (int c = 0; c < tbl[i].n; c++) begin
        drive(tbl[i].p0, tbl[i].u0, tbl[i].p1, tbl[i].u1, tbl[i].clr);
        @(posedge counter10h);
        #1;
        check_all($sformatf("r%0d.%0d", i, c), exp0, tbl[i].h0, tbl[i].m0, tbl[i].k0,
                  tbl[i].sc1, tbl[i].h1, tbl[i].m1, tbl[i].k1);
      end
    end

    // Asynchronous reset in the middle of a round.
    drive('h12, 'h00, 'h78, 'h00, 0);
    @(posedge counter10h); #1;                    // ch1 loads 0x78
    drive('h5A, 'h00, 'h78, 'h00, 0);
    @(posedge counter10h); #1;                    // ch0 loads 0x5A
    @(posedge counter10h); #1;                    // ch0 ramp 1, ch1 ramp 2
    drive('h5A, 'h00, 'h78, 'h78, 0);
    @(posedge counter10h); #1;                    // ch0 ramp 2, ch1 hit award 2
    $display("pre-reset: c1 score=%0d hit=%0d", score_out[2*SW-1:SW], hit_pulse[1]);
    check_all("prerst", 0, 0, 0, 0, 2, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-round");
    check_all("asyncrst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge counter10h);
    drive('h5A, 'h00, 'h78, 'h00, 0);
    rst_n = 1'b1;
    @(posedge counter10h); #1;                    // reload 0x5A at ramp 0
    check_all("rel0", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge counter10h);             // ramp 1..3
    #1;
    drive('h5A, 'h5A, 'h78, 'h00, 0);
    @(posedge counter10h); #1;
    $display("post-reset hit: c0 score=%0d", score_out[SW-1:0]);
    check_all("relhit", 3, 1, 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
